// File: rtl/vga_box_render.sv
// Bouncing-square pixel stage downstream of the VGA sync generator: moves a box once per frame
// and renders it with 1-clk registered RGB and matching sync. Optional border: VGA_BOX_BORDER_EN.
module vga_box_render #(
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [11:0] box_color,
    input  logic        pause,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic [7:0]  bounce_cnt
);

    localparam logic [10:0] BOX_W   = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);
    localparam logic [9:0]  X_RST   = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  Y_RST   = 10'((V_ACTIVE - BOX_SIZE) / 2);

    logic        vs_d_r;
    logic [9:0]  box_x_r;
    logic [9:0]  box_y_r;
    logic        dir_x_r;
    logic        dir_y_r;
    logic [11:0] color_q_r;

    logic        frame_tick_s;
    logic [10:0] next_x_s;
    logic [10:0] next_y_s;
    logic        next_dx_s;
    logic        next_dy_s;
    logic        bounce_x_s;
    logic        bounce_y_s;
    logic        inside_s;
    logic [11:0] rgb_s;

    assign frame_tick_s = vs_d_r & ~vsync_in;

    // Horizontal step with clamp-and-reverse at either edge (11-bit sums avoid wrap)
    always_comb begin
        next_x_s   = {1'b0, box_x_r};
        next_dx_s  = dir_x_r;
        bounce_x_s = 1'b0;
        if (dir_x_r) begin
            if ({1'b0, box_x_r} + BOX_W + STEP_W >= H_ACT_W) begin
                next_x_s   = H_ACT_W - BOX_W;
                next_dx_s  = 1'b0;
                bounce_x_s = 1'b1;
            end else begin
                next_x_s = {1'b0, box_x_r} + STEP_W;
            end
        end else begin
            if ({1'b0, box_x_r} <= STEP_W) begin
                next_x_s   = 11'd0;
                next_dx_s  = 1'b1;
                bounce_x_s = 1'b1;
            end else begin
                next_x_s = {1'b0, box_x_r} - STEP_W;
            end
        end
    end

    // Vertical step, same rule as horizontal
    always_comb begin
        next_y_s   = {1'b0, box_y_r};
        next_dy_s  = dir_y_r;
        bounce_y_s = 1'b0;
        if (dir_y_r) begin
            if ({1'b0, box_y_r} + BOX_W + STEP_W >= V_ACT_W) begin
                next_y_s   = V_ACT_W - BOX_W;
                next_dy_s  = 1'b0;
                bounce_y_s = 1'b1;
            end else begin
                next_y_s = {1'b0, box_y_r} + STEP_W;
            end
        end else begin
            if ({1'b0, box_y_r} <= STEP_W) begin
                next_y_s   = 11'd0;
                next_dy_s  = 1'b1;
                bounce_y_s = 1'b1;
            end else begin
                next_y_s = {1'b0, box_y_r} - STEP_W;
            end
        end
    end

    assign inside_s = ({1'b0, pixel_x} >= {1'b0, box_x_r}) &&
                      ({1'b0, pixel_x} <  {1'b0, box_x_r} + BOX_W) &&
                      ({1'b0, pixel_y} >= {1'b0, box_y_r}) &&
                      ({1'b0, pixel_y} <  {1'b0, box_y_r} + BOX_W);

    // Pixel colour selection ahead of the output register
    always_comb begin
        rgb_s = 12'h000;
        if (video_on) begin
`ifdef VGA_BOX_BORDER_EN
            if ((pixel_x == 10'd0) || (pixel_x == 10'(H_ACTIVE - 1)) ||
                (pixel_y == 10'd0) || (pixel_y == 10'(V_ACTIVE - 1))) begin
                rgb_s = 12'hFFF;
            end else if (inside_s) begin
                rgb_s = color_q_r;
            end else begin
                rgb_s = BG_COLOR;
            end
`else
            if (inside_s) begin
                rgb_s = color_q_r;
            end else begin
                rgb_s = BG_COLOR;
            end
`endif
        end else begin
            rgb_s = 12'h000;
        end
    end

    // Output pipeline, frame-edge detect and motion state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d_r     <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            rgb        <= 12'h000;
            box_x_r    <= X_RST;
            box_y_r    <= Y_RST;
            dir_x_r    <= 1'b1;
            dir_y_r    <= 1'b1;
            color_q_r  <= 12'hFFF;
            bounce_cnt <= 8'd0;
        end else begin
            vs_d_r <= vsync_in;
            hsync  <= hsync_in;
            vsync  <= vsync_in;
            rgb    <= rgb_s;
            if (frame_tick_s) begin
                // Colour latches every frame so it never tears, even while paused
                color_q_r <= box_color;
                if (!pause) begin
                    box_x_r <= next_x_s[9:0];
                    box_y_r <= next_y_s[9:0];
                    dir_x_r <= next_dx_s;
                    dir_y_r <= next_dy_s;
                    if (bounce_x_s || bounce_y_s) begin
                        bounce_cnt <= bounce_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_box_render.sv
// Randomized self-checking bench for vga_box_render against a frame-level model of box motion
// and pixel colour; honours VGA_BOX_BORDER_EN in the model.
module tb_vga_box_render;

    localparam int          BOX = 32;
    localparam int          STP = 2;
    localparam int          HA  = 640;
    localparam int          VA  = 480;
    localparam logic [11:0] BG  = 12'h000;

    logic        clk;
    logic        rst_n;
    logic        hsync_in;
    logic        vsync_in;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] box_color;
    logic        pause;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [7:0]  bounce_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_x;
    int          m_y;
    bit          m_dx;
    bit          m_dy;
    logic [11:0] m_color;
    int          m_bounce;

    vga_box_render #(
        .BOX_SIZE(BOX), .STEP(STP), .H_ACTIVE(HA), .V_ACTIVE(VA), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .box_color(box_color), .pause(pause), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .bounce_cnt(bounce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = (HA - BOX) / 2;
        m_y = (VA - BOX) / 2;
        m_dx = 1'b1;
        m_dy = 1'b1;
        m_color = 12'hFFF;
        m_bounce = 0;
    endtask

    // Advance one axis by one frame; returns 1 when it hit a wall
    function automatic bit move_axis(inout int pos, inout bit dir, input int limit);
        if (dir) begin
            if (pos + STP + BOX >= limit) begin
                pos = limit - BOX; dir = 1'b0; return 1'b1;
            end
            pos = pos + STP;
        end else begin
            if (pos <= STP) begin
                pos = 0; dir = 1'b1; return 1'b1;
            end
            pos = pos - STP;
        end
        return 1'b0;
    endfunction

    function automatic logic [11:0] exp_rgb(input bit vo, input int x, input int y);
        if (!vo) return 12'h000;
`ifdef VGA_BOX_BORDER_EN
        if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 12'hFFF;
`endif
        if (x >= m_x && x < m_x + BOX && y >= m_y && y < m_y + BOX) return m_color;
        return BG;
    endfunction

    task automatic probe(input string tag, input bit vo, input int x, input int y);
        video_on = vo;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        step();
        check(tag, 32'(rgb), 32'(exp_rgb(vo, x, y)));
    endtask

    task automatic probe_box();
        probe("px_tl", 1'b1, m_x, m_y);
        probe("px_br", 1'b1, m_x + BOX - 1, m_y + BOX - 1);
        probe("px_right", 1'b1, m_x + BOX, m_y);
        probe("px_below", 1'b1, m_x, m_y + BOX);
        if (m_x > 0) probe("px_left", 1'b1, m_x - 1, m_y + BOX / 2);
        if (m_y > 0) probe("px_above", 1'b1, m_x + BOX / 2, m_y - 1);
        probe("px_rand", 1'($urandom_range(0, 3) != 0),
              int'($urandom_range(0, HA - 1)), int'($urandom_range(0, VA - 1)));
        video_on = 1'b0;
    endtask

    task automatic do_frame(input bit p, input logic [11:0] c);
        bit bx;
        bit by;
        pause = p;
        box_color = c;
        vsync_in = 1'b0;
        #2;
        check("vsync_pre", 32'(vsync), 32'd1);
        step();
        check("vsync_dly", 32'(vsync), 32'd0);
        m_color = c;
        if (!p) begin
            bx = move_axis(m_x, m_dx, HA);
            by = move_axis(m_y, m_dy, VA);
            if (bx || by) m_bounce = (m_bounce + 1) % 256;
        end
        step();
        step();
        vsync_in = 1'b1;
        step();
        check("vsync_rise", 32'(vsync), 32'd1);
        check("bounce_cnt", 32'(bounce_cnt), 32'(m_bounce));
        pause = 1'b0;
        probe_box();
    endtask

    initial begin
        rst_n = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        video_on = 1'b0;
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        box_color = 12'h000;
        pause = 1'b0;
        model_reset();

        #23;
        check("rst_rgb", 32'(rgb), 32'h000);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_bounce", 32'(bounce_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_hsync", 32'(hsync), 32'd1);
        probe_box();

        // hsync passes through with exactly one clk of delay
        hsync_in = 1'b0;
        #2;
        check("hsync_pre", 32'(hsync), 32'd1);
        step();
        check("hsync_dly", 32'(hsync), 32'd0);
        hsync_in = 1'b1;
        step();
        check("hsync_rise", 32'(hsync), 32'd1);

        // First frame: box moves to (306,226), colour F00 latched
        do_frame(1'b0, 12'hF00);
        probe("tp_inside", 1'b1, 310, 230);
        probe("tp_origin", 1'b1, 0, 0);
        probe("tp_blank", 1'b0, 310, 230);

        // Paused across three ticks while colour changes
        for (int i = 0; i < 3; i++) do_frame(1'b1, 12'h0F0);

        // Long random run: covers wall bounces on both axes in both directions
        for (int f = 0; f < 800; f++) begin
            do_frame(1'($urandom_range(0, 3) == 0), 12'($urandom_range(0, 4095)));
        end

        // Asynchronous reset mid-frame with a visible pixel in the output register
        do_frame(1'b0, 12'hABC);
        probe("pre_rst_px", 1'b1, m_x + 1, m_y + 1);
        video_on = 1'b1;
        hsync_in = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rgb", 32'(rgb), 32'h000);
        check("arst_bounce", 32'(bounce_cnt), 32'd0);
        check("arst_hsync", 32'(hsync), 32'd1);
        check("arst_vsync", 32'(vsync), 32'd1);
        model_reset();
        hsync_in = 1'b1;
        video_on = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        probe_box();
        do_frame(1'b0, 12'h123);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
